// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier job scheduler: FSM state
// encoding and default parameter values.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/matmul_rr_arb2.sv
// Two-way round-robin arbiter: one-hot winner from req, with a priority
// pointer that moves away from the winner whenever upd is strobed.
module matmul_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win
);

  logic ptr_q, ptr_d;  // 0: requester 0 favoured, 1: requester 1 favoured

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    win   = 2'b00;
    ptr_d = ptr_q;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr_q ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
    if (upd) ptr_d = win[0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/matmul_sched.sv
// Job scheduler for a shared matrix multiplier: arbitrates two requesters,
// sequences clear/run of the multiplier and aborts jobs that exceed TIMEOUT.
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             mm_reset,
  output logic             mm_enable,
  input  logic             mm_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       arb_req, arb_win;
  logic             arb_upd;

  // Outside IDLE the arbiter sees only the current owner, so its winner at
  // update time is exactly the requester being served.
  assign arb_req = (state_q == ST_IDLE) ? req : win_q;
  assign arb_upd = (state_q == ST_RUN) &&
                   (state_d == ST_DONE || state_d == ST_ABORT);

  matmul_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .upd   (arb_upd),
    .win   (arb_win)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d   = arb_win;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (mm_rdy) begin
          state_d = ST_DONE;
          count_d = count_q + 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_DONE, ST_ABORT: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      win_q   <= 2'b00;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // mm_reset follows reset directly so an in-flight multiplication is cleared.
  assign gnt       = (state_q == ST_IDLE)  ? 2'b00 : win_q;
  assign done      = (state_q == ST_DONE)  ? win_q : 2'b00;
  assign err       = (state_q == ST_ABORT) ? win_q : 2'b00;
  assign mm_reset  = reset || state_q == ST_CLEAR || state_q == ST_ABORT;
  assign mm_enable = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign job_count = count_q;

endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum RUN-state cycles allowed before a job is aborted; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of job_count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req  input  2  per-requester job request; level, held by the requester until its done or err pulse.
REQ-006 gnt  output  2  one-hot grant; identifies the requester that owns the multiplier.
REQ-007 done  output  2  one-cycle pulse to the granted requester on successful completion.
REQ-008 err  output  2  one-cycle pulse to the granted requester on timeout abort.
REQ-009 mm_reset  output  1  drives the matrix multiplier's active-high reset.
REQ-010 mm_enable  output  1  drives the multiplier's enable.
REQ-011 mm_rdy  input  1  multiplier result-ready flag.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 job_count  output  CNT_W  count of successfully completed jobs; wraps modulo 2^CNT_W.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, RUN, DONE and ABORT; all outputs except job_count are decoded from the registered state and grant (Moore).
REQ-015 IDLE: if any req bit is high, select a winner by round-robin and go to CLEAR; otherwise stay in IDLE.
REQ-016 Round-robin: a priority pointer SHALL favour the requester not served last; on simultaneous requests the favoured requester wins; with a single request that requester wins regardless of the pointer.
REQ-017 The pointer SHALL update only on entry to DONE or ABORT, and SHALL point away from the requester just served.
REQ-018 CLEAR (exactly 1 cycle): mm_reset=1, mm_enable=0; the timeout counter is cleared; next state RUN.
REQ-019 RUN: mm_enable=1, mm_reset=0; the timeout counter increments each cycle; if mm_rdy=1 go to DONE; else if the counter equals TIMEOUT-1 go to ABORT.
REQ-020 mm_rdy=1 in the same cycle the counter reaches TIMEOUT-1 SHALL count as success (go to DONE).
REQ-021 DONE (exactly 1 cycle): done[winner]=1, mm_enable=0, job_count increments by 1; next state IDLE.
REQ-022 ABORT (exactly 1 cycle): err[winner]=1, mm_reset=1, mm_enable=0, job_count unchanged; next state IDLE.
REQ-023 gnt[winner] SHALL be high from CLEAR through DONE or ABORT inclusive and 0 in IDLE.
REQ-024 Deassertion of the winner's req during CLEAR or RUN SHALL be ignored; the job completes or aborts normally.
REQ-025 mm_rdy while not in RUN SHALL be ignored.
REQ-026 A req still high in the IDLE cycle after DONE or ABORT SHALL be treated as a new job; minimum spacing between grants is one IDLE cycle.
REQ-027 done and err SHALL never be high in the same cycle, and at most one bit of gnt, done or err SHALL be high at any time.

Reset
REQ-028 Reset SHALL force: state IDLE, gnt=0, done=0, err=0, mm_enable=0, busy=0, job_count=0, pointer favouring requester 0, timeout counter=0.
REQ-029 mm_reset SHALL be 1 while reset is high, so an in-flight multiplication is cleared; no done or err pulse is emitted for a job aborted by reset.
REQ-030 Reset SHALL take priority over every state transition in the same cycle.

Structure
REQ-031 Package matmul_pkg SHALL hold the state encoding and the default TIMEOUT and CNT_W constants.
REQ-032 The two-way round-robin arbiter SHALL be a sub-module, matmul_rr_arb2: inputs req[1:0] and update strobe; outputs one-hot winner; holds the pointer.
REQ-033 The timeout counter width SHALL be the minimum width that holds TIMEOUT-1.

Verification
REQ-034 With an order-2 multiplier attached, A=[1,2;3,4], B=[5,6;7,8], req=01 -> gnt=01, a single done=01 pulse, C=[19,22;43,50], job_count=1.
REQ-035 req=11 from reset -> requester 0 is served first, then requester 1, alternating; done pulses 01, 10, 01, ...; no gap longer than one IDLE cycle between jobs.
REQ-036 mm_rdy tied low, TIMEOUT=16, req=10 -> err=10 pulse exactly 16 cycles after RUN entry; mm_reset=1 in ABORT; job_count unchanged.
REQ-037 mm_rdy rises in the cycle the counter reaches TIMEOUT-1 -> done pulse, no err.
REQ-038 reset asserted mid-RUN -> next cycle IDLE, all outputs at reset values, no done or err pulse; a subsequent req=01 is granted normally.
REQ-039 req dropped during RUN -> job still completes with a done pulse; with job_count preloaded to 0xFFFF, one completion -> job_count=0.
